ece453_input_cond: RTL and testbench

Input conditioning stage that sits directly upstream of the ECE453 Avalon register block. It takes raw board inputs (push-buttons, slide switches) and synchronises each one to `clk`. Each input is then debounced against a shared millisecond-scale tick. The block produces a clean level vector for `gpio_inputs`, single-cycle rise/fall pulses for the FSM `button` input, and an optional sticky event register with its own interrupt.

---
 rtl/ece453_input_cond_pkg.sv | 19 +
 rtl/ece453_input_chan.sv | 61 ++++++
 rtl/ece453_input_cond.sv | 75 +++++++
 tb/tb_ece453_input_cond.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ece453_input_cond_pkg.sv
// Shared constants and sizing helpers for the ECE453 input conditioning stage.
// Imported by ece453_input_cond and ece453_input_chan.
package ece453_input_cond_pkg;

    localparam int         TICK_DIV_DEFAULT     = 50000;
    localparam int         STABLE_TICKS_DEFAULT = 8;
    localparam logic [7:0] INVERT_MASK_DEFAULT  = 8'h0F;

    // Debounce counter must hold STABLE_TICKS-1 with a spare bit of headroom.
    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks) + 1;
    endfunction

    // A divide-by-one prescaler still needs a one-bit register.
    function automatic int pre_width(input int tick_div);
        return (tick_div > 1) ? $clog2(tick_div) : 1;
    endfunction

endpackage

// File: rtl/ece453_input_chan.sv
// One input channel: polarity fix, 2-flop synchroniser, tick-based debounce,
// debounced level and single-cycle rise/fall pulses.
module ece453_input_chan
    import ece453_input_cond_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter bit INVERT       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw ^ INVERT;
            sync2 <= sync1;
        end
    end

    // Any return to the accepted level clears the count, so short glitches
    // never accumulate across separate mismatch episodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    rise  <= sync2;
                    fall  <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ece453_input_cond.sv
// Input conditioning top: shared debounce prescaler, per-channel debouncers and
// the sticky rise-event register (enabled by ECE453_INPUT_COND_STICKY_EN).
module ece453_input_cond
    import ece453_input_cond_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int               STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter logic [WIDTH-1:0] INVERT_MASK  = WIDTH'(INVERT_MASK_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    input  logic [WIDTH-1:0] event_clr,
    output logic [WIDTH-1:0] event_r,
    output logic             irq_out
);

    localparam int            PW        = pre_width(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick;

    assign tick = (pre_cnt == TICK_LAST);

    // With TICK_DIV=1 the counter sits at zero and tick is permanently high.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        ece453_input_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .INVERT       (INVERT_MASK[i])
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_in[i]),
            .tick  (tick),
            .level (level_out[i]),
            .rise  (rise_pulse[i]),
            .fall  (fall_pulse[i])
        );
    end

`ifdef ECE453_INPUT_COND_STICKY_EN
    // A rise in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_r <= '0;
        end else begin
            event_r <= (event_r & ~event_clr) | rise_pulse;
        end
    end

    assign irq_out = |event_r;
`else
    logic unused_event_clr;

    assign unused_event_clr = ^event_clr;
    assign event_r          = '0;
    assign irq_out          = 1'b0;
`endif

endmodule

// File: tb/tb_ece453_input_cond.sv
// Scoreboard bench for ece453_input_cond (WIDTH=4, TICK_DIV=4, STABLE_TICKS=3).
// Expected edge pulses are queued with a cycle window; a monitor pops and checks.
module tb_ece453_input_cond;

`ifdef ECE453_INPUT_COND_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    // Latency window for TICK_DIV=4, STABLE_TICKS=3: 2+2*4+1 .. 2+3*4.
    localparam int LAT_MIN = 11;
    localparam int LAT_MAX = 14;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw_in;
    logic [3:0] level_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic [3:0] event_clr;
    logic [3:0] event_r;
    logic       irq_out;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] rise;
        logic [3:0] fall;
        int         lo;
        int         hi;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    ece453_input_cond #(
        .WIDTH        (4),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .INVERT_MASK  (4'b0001)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .event_clr  (event_clr),
        .event_r    (event_r),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the head of the queue inside its window.
    always @(negedge clk) begin
        exp_t e;
        if ((rise_pulse | fall_pulse) != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse: rise=%b fall=%b at cycle %0d, required none",
                         rise_pulse, fall_pulse, cyc);
            end else begin
                e = exp_q.pop_front();
                if (rise_pulse !== e.rise || fall_pulse !== e.fall ||
                    cyc < e.lo || cyc > e.hi ||
                    (level_out & e.rise) !== e.rise || (level_out & e.fall) !== 4'b0000) begin
                    errors++;
                    $display("[TB] FAIL %s: rise=%b fall=%b level=%b cycle=%0d, required rise=%b fall=%b cycle %0d..%0d",
                             e.name, rise_pulse, fall_pulse, level_out, cyc, e.rise, e.fall, e.lo, e.hi);
                end
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].hi) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: no pulse by cycle %0d, required rise=%b fall=%b in %0d..%0d",
                     e.name, cyc, e.rise, e.fall, e.lo, e.hi);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] raw, input logic [3:0] clr);
        @(negedge clk);
        raw_in    = raw;
        event_clr = clr;
    endtask

    task automatic expectEdge(input string name, input logic [3:0] r, input logic [3:0] f, input int base);
        exp_t e;
        e.rise = r;
        e.fall = f;
        e.lo   = base + LAT_MIN;
        e.hi   = base + LAT_MAX;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: %0d expected pulses still pending after %0d cycles, required 0",
                     name, exp_q.size(), budget);
        end
    endtask

    task automatic waitRise(input string name, input int ch, output bit found);
        found = 1'b0;
        for (int n = 0; n < 25 && !found; n++) begin
            @(negedge clk);
            if (rise_pulse[ch]) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: rise_pulse[%0d] got 0 for 25 cycles, required 1", name, ch);
        end
    endtask

    initial begin
        bit found;
        int base;

        reset     = 1'b1;
        raw_in    = 4'b0001;
        event_clr = 4'b0000;

        // Reset with ch0 idle-high (inverted to 0)
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_level", level_out, 4'b0000);
        checkOutput("reset_rise", rise_pulse, 4'b0000);
        checkOutput("reset_fall", fall_pulse, 4'b0000);
        checkOutput("reset_event", event_r, 4'b0000);
        checkOutput("reset_irq", irq_out, 1'b0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("idle_level", level_out, 4'b0000);

        // Clean press on ch1
        applyStimulus(4'b0011, 4'b0000);
        expectEdge("press1_rise", 4'b0010, 4'b0000, cyc);
        waitRise("press1_wait", 1, found);
        if (found) begin
            checkOutput("press1_event_before", event_r, 4'b0000);
            @(negedge clk);
            checkOutput("press1_event", event_r, STICKY ? 4'b0010 : 4'b0000);
            checkOutput("press1_irq", irq_out, STICKY);
        end
        waitIdle("press1_idle", 5);

        applyStimulus(4'b0001, 4'b0000);
        expectEdge("release1_fall", 4'b0000, 4'b0010, cyc);
        waitIdle("release1_idle", 30);

        // Clear coinciding with a new rise: set must win
        applyStimulus(4'b0011, 4'b0000);
        expectEdge("repress1_rise", 4'b0010, 4'b0000, cyc);
        waitRise("repress1_wait", 1, found);
        if (found) begin
            event_clr = 4'b0010;
            @(negedge clk);
            event_clr = 4'b0000;
            checkOutput("set_wins_event", event_r, STICKY ? 4'b0010 : 4'b0000);
        end
        waitIdle("repress1_idle", 5);

        // Lone clear
        applyStimulus(4'b0011, 4'b0010);
        applyStimulus(4'b0011, 4'b0000);
        checkOutput("lone_clear_event", event_r, 4'b0000);
        checkOutput("lone_clear_irq", irq_out, 1'b0);

        applyStimulus(4'b0001, 4'b0000);
        expectEdge("release1b_fall", 4'b0000, 4'b0010, cyc);
        waitIdle("release1b_idle", 30);

        // Glitch of 8 cycles on ch2 must be rejected
        applyStimulus(4'b0101, 4'b0000);
        repeat (7) @(negedge clk);
        applyStimulus(4'b0001, 4'b0000);
        repeat (20) @(negedge clk);
        checkOutput("glitch8_level", level_out, 4'b0000);

        // 15-cycle pulse on ch2 is accepted, then released
        applyStimulus(4'b0101, 4'b0000);
        base = cyc;
        expectEdge("pulse15_rise", 4'b0100, 4'b0000, base);
        repeat (14) @(negedge clk);
        applyStimulus(4'b0001, 4'b0000);
        expectEdge("pulse15_fall", 4'b0000, 4'b0100, base + 15);
        waitIdle("pulse15_idle", 40);
        checkOutput("pulse15_event", event_r, STICKY ? 4'b0100 : 4'b0000);
        applyStimulus(4'b0001, 4'b0100);
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("pulse15_clear_irq", irq_out, 1'b0);

        // Active-low ch0 press and release
        applyStimulus(4'b0000, 4'b0000);
        expectEdge("key0_rise", 4'b0001, 4'b0000, cyc);
        waitIdle("key0_press_idle", 30);
        checkOutput("key0_level", level_out, 4'b0001);
        applyStimulus(4'b0001, 4'b0000);
        expectEdge("key0_fall", 4'b0000, 4'b0001, cyc);
        waitIdle("key0_release_idle", 30);
        checkOutput("key0_event", event_r, STICKY ? 4'b0001 : 4'b0000);
        applyStimulus(4'b0001, 4'b0001);
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("key0_clear_event", event_r, 4'b0000);

        // Reset while ch3 count is at 2 restarts its debounce
        applyStimulus(4'b1001, 4'b0000);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_level", level_out, 4'b0000);
        checkOutput("midreset_rise", rise_pulse, 4'b0000);
        reset = 1'b0;
        expectEdge("midreset_rise3", 4'b1000, 4'b0000, cyc);
        waitIdle("midreset_idle", 30);
        checkOutput("midreset_level3", level_out, 4'b1000);
        @(negedge clk);
        checkOutput("midreset_event", event_r, STICKY ? 4'b1000 : 4'b0000);
        checkOutput("midreset_irq", irq_out, STICKY);

        repeat (5) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
